stack_unit: RTL and testbench

Parametrised hardware stack that succeeds the fixed 8-bit, 8-bit-address stack-pointer and RAM pair in the mpp datapath. It holds `DEPTH` words of `DATA_W` bits, presents the top of stack as a registered output, and supports push, pop, simultaneous replace-top and synchronous clear. It reports full/empty status and sticky overflow/underflow error flags. It sits beside the accumulator and register bank on the data bus and backs CALL/RET and PUSH/POP microcode.

---
 rtl/stack_unit.sv | 121 ++++++++++++
 tb/tb_stack_unit.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/stack_unit.sv
// Parametrised LIFO stack with a registered top-of-stack output, replace-top,
// synchronous clear, full/empty status and sticky overflow/underflow flags.
module stack_unit #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              clear,
    input  logic              err_clr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO_CNT  = CNT_W'(2);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] top_q, top_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;

    logic              is_empty, is_full;
    logic              do_push, do_pop, do_replace;
    logic              ovf_set, udf_set;
    logic              mem_we;
    logic [CNT_W-1:0]  wr_idx, rd_idx;
    logic [DATA_W-1:0] below_top;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == FULL_CNT);

    // Push+pop on an empty stack degrades to a plain push and is never an error.
    always_comb begin
        do_push    = 1'b0;
        do_pop     = 1'b0;
        do_replace = 1'b0;
        ovf_set    = 1'b0;
        udf_set    = 1'b0;
        if (!clear) begin
            if (push && pop) begin
                do_replace = !is_empty;
                do_push    = is_empty;
            end else if (push) begin
                do_push = !is_full;
                ovf_set = is_full;
            end else if (pop) begin
                do_pop  = !is_empty;
                udf_set = is_empty;
            end
        end
    end

    assign mem_we = do_push || do_replace;
    assign wr_idx = do_replace ? (count_q - ONE_CNT) : count_q;
    assign rd_idx = count_q - TWO_CNT;
    assign below_top = (count_q >= TWO_CNT) ? mem[rd_idx[AW-1:0]] : '0;

    always_comb begin
        count_d = count_q;
        top_d   = top_q;
        if (clear) begin
            count_d = '0;
            top_d   = '0;
        end else if (do_push) begin
            count_d = count_q + ONE_CNT;
            top_d   = data_in;
        end else if (do_replace) begin
            top_d   = data_in;
        end else if (do_pop) begin
            count_d = count_q - ONE_CNT;
            top_d   = below_top;
        end
    end

    // A set on the same edge as err_clr wins.
    always_comb begin
        ovf_d = (ovf_q && !err_clr) || ovf_set;
        udf_d = (udf_q && !err_clr) || udf_set;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            top_q   <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            top_q   <= top_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_idx[AW-1:0]] <= data_in;
        end
    end

    assign data_out  = top_q;
    assign count     = count_q;
    assign empty     = is_empty;
    assign full      = is_full;
    assign overflow  = ovf_q;
    assign underflow = udf_q;

endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit (DATA_W=8, DEPTH=4): inputs change and outputs
// are sampled on the falling edge, half a period away from the active edge.
module tb_stack_unit;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk;
    logic              reset;
    logic              push;
    logic              pop;
    logic              clear;
    logic              err_clr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              underflow;

    int n_cmp = 0;
    int n_err = 0;

    stack_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .clear    (clear),
        .err_clr  (err_clr),
        .data_in  (data_in),
        .data_out (data_out),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .overflow (overflow),
        .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a falling edge: apply inputs, let one rising edge pass, return
    // at the next falling edge with inputs back to idle.
    task automatic cycle(input logic p, input logic q, input logic c,
                         input logic e, input logic [DATA_W-1:0] d);
        push    = p;
        pop     = q;
        clear   = c;
        err_clr = e;
        data_in = d;
        @(negedge clk);
        push    = 1'b0;
        pop     = 1'b0;
        clear   = 1'b0;
        err_clr = 1'b0;
        data_in = '0;
    endtask

    task automatic check(input string tag, input int exp_cnt,
                         input logic [DATA_W-1:0] exp_dout, input logic exp_emp,
                         input logic exp_ful, input logic exp_ovf, input logic exp_udf);
        logic [CNT_W-1:0] ec;
        ec = CNT_W'(exp_cnt);
        n_cmp++;
        assert (count === ec) else begin
            n_err++;
            $error("FAIL %s count: got %0d expected %0d", tag, count, ec);
        end
        n_cmp++;
        assert (data_out === exp_dout) else begin
            n_err++;
            $error("FAIL %s data_out: got %02h expected %02h", tag, data_out, exp_dout);
        end
        n_cmp++;
        assert (empty === exp_emp) else begin
            n_err++;
            $error("FAIL %s empty: got %b expected %b", tag, empty, exp_emp);
        end
        n_cmp++;
        assert (full === exp_ful) else begin
            n_err++;
            $error("FAIL %s full: got %b expected %b", tag, full, exp_ful);
        end
        n_cmp++;
        assert (overflow === exp_ovf) else begin
            n_err++;
            $error("FAIL %s overflow: got %b expected %b", tag, overflow, exp_ovf);
        end
        n_cmp++;
        assert (underflow === exp_udf) else begin
            n_err++;
            $error("FAIL %s underflow: got %b expected %b", tag, underflow, exp_udf);
        end
    endtask

    initial begin
        reset   = 1'b1;
        push    = 1'b0;
        pop     = 1'b0;
        clear   = 1'b0;
        err_clr = 1'b0;
        data_in = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        cycle(0, 0, 0, 0, 8'h00);
        cycle(0, 0, 0, 0, 8'h00);
        cycle(0, 0, 0, 0, 8'h00);
        check("reset_idle", 0, 8'h00, 1, 0, 0, 0);

        cycle(1, 0, 0, 0, 8'h11); check("push1", 1, 8'h11, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 8'h22); check("push2", 2, 8'h22, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 8'h33); check("push3", 3, 8'h33, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 8'h44); check("push4", 4, 8'h44, 0, 1, 0, 0);
        cycle(1, 0, 0, 0, 8'h55); check("push_full", 4, 8'h44, 0, 1, 1, 0);

        cycle(0, 1, 0, 0, 8'h00); check("pop1", 3, 8'h33, 0, 0, 1, 0);
        cycle(0, 1, 0, 0, 8'h00); check("pop2", 2, 8'h22, 0, 0, 1, 0);
        cycle(0, 1, 0, 0, 8'h00); check("pop3", 1, 8'h11, 0, 0, 1, 0);
        cycle(0, 1, 0, 0, 8'h00); check("pop4", 0, 8'h00, 1, 0, 1, 0);
        cycle(0, 1, 0, 0, 8'h00); check("pop_empty", 0, 8'h00, 1, 0, 1, 1);

        cycle(0, 1, 0, 1, 8'h00); check("errclr_with_pop", 0, 8'h00, 1, 0, 0, 1);
        cycle(0, 0, 0, 1, 8'h00); check("errclr_alone", 0, 8'h00, 1, 0, 0, 0);

        cycle(1, 0, 0, 0, 8'hA0); check("push_a0", 1, 8'hA0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 8'hA1); check("push_a1", 2, 8'hA1, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 8'hB7); check("replace_b7", 2, 8'hB7, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 8'h00); check("pop_below", 1, 8'hA0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 8'h00); check("pop_to_empty", 0, 8'h00, 1, 0, 0, 0);

        cycle(1, 1, 0, 0, 8'h3C); check("pushpop_empty", 1, 8'h3C, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 8'h00); check("pop_3c", 0, 8'h00, 1, 0, 0, 0);

        cycle(1, 0, 0, 0, 8'h01); check("fill1", 1, 8'h01, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 8'h02); check("fill2", 2, 8'h02, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 8'h03); check("fill3", 3, 8'h03, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 8'h04); check("fill4", 4, 8'h04, 0, 1, 0, 0);
        cycle(1, 0, 0, 0, 8'h05); check("fill_ovf", 4, 8'h04, 0, 1, 1, 0);
        cycle(1, 0, 1, 0, 8'h77); check("clear_with_push", 0, 8'h00, 1, 0, 1, 0);
        cycle(1, 1, 1, 0, 8'h78); check("clear_pushpop", 0, 8'h00, 1, 0, 1, 0);
        cycle(0, 0, 0, 1, 8'h00); check("errclr_ovf", 0, 8'h00, 1, 0, 0, 0);

        cycle(1, 0, 0, 0, 8'h61); check("pre_rst1", 1, 8'h61, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 8'h62); check("pre_rst2", 2, 8'h62, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 8'h00); check("pre_rst_pop", 1, 8'h61, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 8'h63); check("pre_rst3", 2, 8'h63, 0, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", 0, 8'h00, 1, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        cycle(1, 0, 0, 0, 8'h99); check("post_rst_push", 1, 8'h99, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 8'h00); check("post_rst_pop", 0, 8'h00, 1, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
